// File: rtl/isa_pkg.sv
// +---------------------------------------------------------------+
// | isa_pkg: opcode map and shared types for the 9-bit core ISA   |
// | rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

package isa_pkg;

  typedef logic [8:0] word_t;

  localparam logic [2:0] OP_LDST  = 3'b000;
  localparam logic [2:0] OP_MOV   = 3'b001;
  localparam logic [2:0] OP_ALU   = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b011;
  localparam logic [2:0] OP_JUMP  = 3'b100;
  localparam logic [2:0] OP_BLT   = 3'b101;
  localparam logic [2:0] OP_BEQ   = 3'b110;
  localparam logic [2:0] OP_IMM   = 3'b111;

  // ALU in_sub=11 selects the unary group; imm[1:0] picks the unary op
  localparam logic [1:0] ALU_UNARY  = 2'b11;
  localparam logic [1:0] UNOP_0     = 2'b00;
  localparam logic [1:0] UNOP_1     = 2'b01;
  localparam logic [1:0] UNOP_2     = 2'b10;
  localparam logic [1:0] UNOP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_t;

  typedef struct packed {
    logic  legal;
    word_t word;
  } enc_result_t;

endpackage

`default_nettype wire

// File: rtl/instr_encoder_if.sv
// +---------------------------------------------------------------+
// | instr_encoder_if: instruction stream in, memory write port out|
// | rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

interface instr_encoder_if #(parameter int ADDR_W = 8);
  import isa_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [2:0]        in_op;
  logic [1:0]        in_sub;
  logic [2:0]        in_ra;
  logic [2:0]        in_rb;
  logic [4:0]        in_imm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  word_t             wr_data;

  modport master (
    output in_valid, in_last, in_op, in_sub, in_ra, in_rb, in_imm,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_last, in_op, in_sub, in_ra, in_rb, in_imm,
    output in_ready, wr_en, wr_addr, wr_data
  );

endinterface

`default_nettype wire

// File: rtl/enc_fifo.sv
// +---------------------------------------------------------------+
// | enc_fifo: synchronous FIFO for encoded words, show-ahead read |
// | rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  // extra pointer bit distinguishes full from empty when indices match
  assign dout  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// +---------------------------------------------------------------+
// | instr_encoder: packs instruction descriptions into 9-bit words|
// | and writes them to consecutive instruction-memory addresses   |
// | rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

module instr_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  instr_encoder_if.slave       bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [3:0]           err_cnt
);

  function automatic enc_result_t encode(input logic [2:0] op, input logic [1:0] sub,
                                         input logic [2:0] ra, input logic [2:0] rb,
                                         input logic [4:0] imm);
    enc_result_t r;
    r.legal = 1'b1;
    r.word  = {op, 6'b0};
    case (op)
      OP_LDST: begin
        if (sub[0]) begin
          r.word[5:0] = {1'b1, ra[1:0], rb};
          r.legal     = !ra[2];
        end else begin
          r.word[5:0] = {1'b0, ra, rb[1:0]};
          r.legal     = !rb[2];
        end
      end
      OP_MOV, OP_BLT, OP_BEQ: r.word[5:0] = {ra, rb};
      OP_ALU: begin
        if (sub == ALU_UNARY) begin
          r.word[5:0] = {sub, imm[1:0], ra[1:0]};
          r.legal     = (imm[1:0] != UNOP_RSVD) && !ra[2];
        end else begin
          r.word[5:0] = {sub, ra[1:0], rb[1:0]};
          r.legal     = !ra[2] && !rb[2];
        end
      end
      OP_SHIFT: begin
        r.word[5:0] = {ra, imm[2:0]};
        r.legal     = (imm[4:3] == 2'b00);
      end
      OP_JUMP: r.word[5:0] = {sub[0], imm};
      OP_IMM: begin
        r.word[5:0] = {sub[0], ra[1:0], imm[2:0]};
        r.legal     = !ra[2] && (imm[4:3] == 2'b00);
      end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  enc_state_t        state, state_next;
  enc_result_t       enc;
  logic              accept, push, pop, fifo_full, fifo_empty;
  word_t             fifo_dout;
  logic [ADDR_W-1:0] addr;
  logic              addr_full;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  word_t             wr_data_q;

  assign enc          = encode(bus.in_op, bus.in_sub, bus.in_ra, bus.in_rb, bus.in_imm);
  assign bus.in_ready = (state == ST_RUN) && !fifo_full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && enc.legal;
  assign pop          = ((state == ST_RUN) || (state == ST_DRAIN)) && !fifo_empty;
  assign busy         = (state == ST_RUN) || (state == ST_DRAIN);
  assign done         = (state == ST_DONE);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;

  enc_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (enc.word),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (accept && bus.in_last) state_next = ST_DRAIN;
      // wait for the final strobe to leave the output register before finishing
      ST_DRAIN: if (fifo_empty && !wr_en_q) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      addr      <= '0;
      addr_full <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state   <= state_next;
      wr_en_q <= 1'b0;
      if ((state == ST_IDLE) && start) begin
        addr      <= '0;
        addr_full <= 1'b0;
        err       <= 1'b0;
        err_cnt   <= '0;
      end
      // once the top address is written, remaining words are drained and dropped
      if (pop) begin
        if (addr_full) begin
          err <= 1'b1;
        end else begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= addr;
          wr_data_q <= fifo_dout;
          if (&addr) addr_full <= 1'b1;
          else       addr      <= addr + 1'b1;
        end
      end
      if (accept && !enc.legal) begin
        err <= 1'b1;
        if (err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// +---------------------------------------------------------------+
// | tb_instr_encoder: directed vector table plus load sequences   |
// | rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

module tb_instr_encoder;
  import isa_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, err;
  logic [3:0] err_cnt;

  instr_encoder_if #(.ADDR_W(8)) bus ();

  instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [1:0] sub;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [4:0] imm;
    bit         legal;
    logic [8:0] word;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [8:0] data;
    int         cyc;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stalls;
  int   acc0;
  vec_t tbl [19];
  vec_t load_q [$];
  wr_t  cap [$];
  logic [8:0] exp_q [$];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.wr_en === 1'b1) cap.push_back(wr_t'{bus.wr_addr, bus.wr_data, cyc});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_op = '0; bus.in_sub = '0;
    bus.in_ra = '0; bus.in_rb = '0; bus.in_imm = '0;
  endtask

  task automatic drive(input vec_t v, input bit last);
    bus.in_valid = 1'b1; bus.in_last = last; bus.in_op = v.op; bus.in_sub = v.sub;
    bus.in_ra = v.ra; bus.in_rb = v.rb; bus.in_imm = v.imm;
  endtask

  // Run one complete load of load_q; writes land in cap
  task automatic run_load();
    int n;
    cap.delete();
    stalls = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < load_q.size(); i++) begin
      drive(load_q[i], i == load_q.size() - 1);
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
        stalls++; @(posedge clk); #1; n++;
      end
      if (n >= 50) begin
        check("ready_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
      if (i == 0) acc0 = cyc;
    end
    idle_inputs();
    check("drain_ready_low", bus.in_ready, 0);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("done_seen", done, 1);
    check("busy_low_at_done", busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
  endtask

  task automatic check_writes(input string name);
    check({name, "_count"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      check({name, "_addr"}, cap[i].addr, i);
      check({name, "_data"}, cap[i].data, exp_q[i]);
    end
  endtask

  initial begin
    tbl[0]  = '{OP_MOV,   2'd0, 3'd5, 3'd2, 5'd0,  1'b1, 9'b001101010};
    tbl[1]  = '{OP_LDST,  2'd0, 3'd3, 3'd1, 5'd0,  1'b1, 9'b000001101};
    tbl[2]  = '{OP_LDST,  2'd1, 3'd2, 3'd6, 5'd0,  1'b1, 9'b000110110};
    tbl[3]  = '{OP_JUMP,  2'd1, 3'd0, 3'd0, 5'd17, 1'b1, 9'b100110001};
    tbl[4]  = '{OP_JUMP,  2'd0, 3'd0, 3'd0, 5'd5,  1'b1, 9'b100000101};
    tbl[5]  = '{OP_ALU,   2'd3, 3'd1, 3'd0, 5'd10, 1'b1, 9'b010111001};
    tbl[6]  = '{OP_IMM,   2'd0, 3'd3, 3'd0, 5'd5,  1'b1, 9'b111011101};
    tbl[7]  = '{OP_IMM,   2'd1, 3'd2, 3'd0, 5'd7,  1'b1, 9'b111110111};
    tbl[8]  = '{OP_ALU,   2'd1, 3'd2, 3'd3, 5'd0,  1'b1, 9'b010011011};
    tbl[9]  = '{OP_SHIFT, 2'd0, 3'd7, 3'd0, 5'd6,  1'b1, 9'b011111110};
    tbl[10] = '{OP_BLT,   2'd0, 3'd4, 3'd1, 5'd0,  1'b1, 9'b101100001};
    tbl[11] = '{OP_BEQ,   2'd0, 3'd0, 3'd7, 5'd0,  1'b1, 9'b110000111};
    tbl[12] = '{OP_LDST,  2'd0, 3'd0, 3'd4, 5'd0,  1'b0, 9'b0};
    tbl[13] = '{OP_LDST,  2'd1, 3'd4, 3'd0, 5'd0,  1'b0, 9'b0};
    tbl[14] = '{OP_ALU,   2'd0, 3'd6, 3'd1, 5'd0,  1'b0, 9'b0};
    tbl[15] = '{OP_ALU,   2'd3, 3'd1, 3'd0, 5'd3,  1'b0, 9'b0};
    tbl[16] = '{OP_SHIFT, 2'd0, 3'd1, 3'd0, 5'd8,  1'b0, 9'b0};
    tbl[17] = '{OP_IMM,   2'd0, 3'd4, 3'd0, 5'd1,  1'b0, 9'b0};
    tbl[18] = '{OP_IMM,   2'd0, 3'd1, 3'd0, 5'd9,  1'b0, 9'b0};

    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);

    // single-instruction loads from the vector table
    for (int i = 0; i < 19; i++) begin
      load_q.delete(); load_q.push_back(tbl[i]);
      run_load();
      if (tbl[i].legal) begin
        exp_q.delete(); exp_q.push_back(tbl[i].word);
        check_writes($sformatf("vec%0d", i));
        if (cap.size() > 0) check($sformatf("vec%0d_latency", i), cap[0].cyc - acc0, 1);
        check($sformatf("vec%0d_err", i), err, 0);
        check($sformatf("vec%0d_err_cnt", i), err_cnt, 0);
      end else begin
        check($sformatf("vec%0d_dropped", i), cap.size(), 0);
        check($sformatf("vec%0d_err", i), err, 1);
        check($sformatf("vec%0d_err_cnt", i), err_cnt, 1);
      end
    end

    // back-to-back ld / st / jump
    load_q = '{tbl[1], tbl[2], tbl[3]};
    exp_q  = '{tbl[1].word, tbl[2].word, tbl[3].word};
    run_load();
    check_writes("stream3");
    check("stream3_err", err, 0);

    // illegal between two legal words
    load_q = '{tbl[0], tbl[14], tbl[1]};
    exp_q  = '{tbl[0].word, tbl[1].word};
    run_load();
    check_writes("mid_illegal");
    check("mid_illegal_err", err, 1);
    check("mid_illegal_err_cnt", err_cnt, 1);

    // six at full rate
    load_q = '{tbl[0], tbl[1], tbl[2], tbl[3], tbl[6], tbl[11]};
    exp_q  = '{tbl[0].word, tbl[1].word, tbl[2].word, tbl[3].word, tbl[6].word, tbl[11].word};
    run_load();
    check_writes("burst6");
    check("burst6_stalls", stalls, 0);
    for (int i = 1; i < cap.size(); i++) check("burst6_consecutive", cap[i].cyc - cap[i-1].cyc, 1);

    // err_cnt saturation
    load_q.delete();
    for (int i = 0; i < 17; i++) load_q.push_back(tbl[12]);
    run_load();
    check("sat_dropped", cap.size(), 0);
    check("sat_err_cnt", err_cnt, 15);

    // address overflow: 257 words into 256 locations
    load_q.delete();
    for (int i = 0; i < 257; i++) load_q.push_back(tbl[0]);
    run_load();
    check("ovf_count", cap.size(), 256);
    if (cap.size() >= 256) begin
      check("ovf_last_addr", cap[255].addr, 255);
      check("ovf_last_data", cap[255].data, tbl[0].word);
    end
    check("ovf_err", err, 1);
    check("ovf_err_cnt", err_cnt, 0);

    // reset in the middle of a load
    cap.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drive(tbl[1], 1'b0);
    @(posedge clk); #1;
    drive(tbl[2], 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    #1;
    check("midrst_wr_en", bus.wr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    cap.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_writes", cap.size(), 0);
    check("midrst_busy_after", busy, 0);

    load_q = '{tbl[0]};
    exp_q  = '{tbl[0].word};
    run_load();
    check_writes("after_rst");
    check("after_rst_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
